stream_wrr_arbiter: RTL and testbench
=====================================

Name: stream_wrr_arbiter

Overview:
- Packet-aware weighted round-robin arbiter for one output port of the stream crossbar fabric.
- Shares a single AXI-Stream-like master port among S_DATA_COUNT slave streams.
- A grant is held for whole packets, up to weight_i[n] packets per turn, then passed to the next requester.
- Used as the per-output scheduler when inputs need unequal bandwidth shares.

Parameters:
T_DATA_WIDTH, 8, data beat width
S_DATA_COUNT, 4, number of input streams (>=2)
WEIGHT_WIDTH, 4, width of per-input packet quota
T_ID___WIDTH, $clog2(S_DATA_COUNT), localparam, id width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
s_data_i  input  T_DATA_WIDTH x S_DATA_COUNT  input beat data (unpacked array)
s_last_i  input  S_DATA_COUNT  last beat of packet per input
s_valid_i  input  S_DATA_COUNT  beat valid per input
s_ready_o  output  S_DATA_COUNT  beat accepted per input
weight_i  input  WEIGHT_WIDTH x S_DATA_COUNT  packets per turn; sampled at grant
m_data_o  output  T_DATA_WIDTH  output data
m_id_o  output  T_ID___WIDTH  index of granted input
m_last_o  output  1  output last
m_valid_o  output  1  output valid
m_ready_i  input  1  downstream ready
busy_o  output  1  high while in XFER

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, grant=0, credit=0, pkt_open=0.
- Outputs during reset: s_ready_o=0, m_valid_o=0, m_last_o=0, m_data_o=0, m_id_o=0, busy_o=0.
- Reset asserted mid-packet aborts the packet; no beat is emitted until re-arbitration after release.
- States: IDLE, XFER.
- IDLE:
  - All s_ready_o=0; m_valid_o=0.
  - If any s_valid_i is set: grant = first valid index searching ptr, ptr+1, ... wrapping modulo S_DATA_COUNT.
  - Load credit = weight_i[grant]; weight 0 is treated as 1.
  - Go to XFER next cycle. Arbitration latency is 1 cycle from valid to first possible beat.
- XFER:
  - Combinational passthrough: m_data_o=s_data_i[grant], m_last_o=s_last_i[grant], m_valid_o=s_valid_i[grant], m_id_o=grant.
  - s_ready_o[grant]=m_ready_i; all other s_ready_o bits are 0.
  - Beat handshake = m_valid_o && m_ready_i.
  - Handshake with last=0: pkt_open=1.
  - Handshake with last=1: pkt_open=0 and credit decrements.
    - If the new credit is 0: go to IDLE, ptr=(grant+1) mod S_DATA_COUNT.
    - Otherwise stay in XFER on the same grant.
  - Packet boundary (pkt_open=0, not on the first cycle of the grant) with s_valid_i[grant]=0: release early, go to IDLE, ptr=grant+1 mod S. Unused credit is discarded.
  - pkt_open=1: grant is never released regardless of stalls; valid deassertion mid-packet just stalls.
- Single-beat packet (valid+last on the first beat): counts as one packet.
- ptr wrap: S-1 -> 0. Non-power-of-2 S is supported; indices >= S are never granted.
- weight_i changes take effect only at the next grant.
- busy_o=1 exactly when state=XFER.
- Packet-to-packet gap across a grant change is 1 idle cycle (IDLE state). Within a grant, packets stream back-to-back with no bubble.

Optional Feature:
- Macro: STREAM_WRR_STATS_EN.
- Defined:
  - Adds output pkt_cnt_o [15:0] per input (unpacked array, S_DATA_COUNT entries).
  - Counts packets accepted (last handshake) per input; wraps at 65535->0.
  - Reset to 0 by rst.
  - Adds input stats_clr_i (1 bit): synchronous clear of all counters. A clear wins over a simultaneous increment.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset mid-packet: input 1 granted, 2 of 4 beats sent, rst pulsed -> all outputs 0 during reset; after release, re-arbitration starts from ptr=0 and input 1 resends from its next offered beat.
- Round robin, S=4, all weights=1, all inputs continuously valid with 2-beat packets -> m_id_o sequence 0,1,2,3,0; exactly one idle cycle between packets; each s_ready_o pulses only while granted.
- Weighted, weight_i={3,1,0,2} for inputs 0..3, all inputs valid with 1-beat packets -> id order 0,0,0,1,2,3,3,0; weight 0 on input 2 behaves as 1.
- Early release: input 0 weight 4 sends one packet then drops valid, input 2 valid -> arbiter returns to IDLE after the packet boundary and grants input 2; input 0 is not granted again until ptr wraps.
- Backpressure mid-packet: m_ready_i low for 5 cycles during beat 2 of a 3-beat packet -> m_data_o/m_id_o held stable, no other input's s_ready_o asserts, packet completes intact.
- STATS_EN: 10 packets from input 3, then stats_clr_i asserted in the same cycle as an 11th last handshake -> pkt_cnt_o[3] reads 10 before the clear and 0 after, with the concurrent increment dropped.

Source files
------------

// File: rtl/stream_wrr_arbiter.sv
// Packet-aware weighted round-robin arbiter sharing one master stream among S_DATA_COUNT slaves.
// Define STREAM_WRR_STATS_EN to add per-input packet counters (pkt_cnt_o) with a synchronous clear.
module stream_wrr_arbiter #(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int S_DATA_COUNT = 4,
  parameter  int WEIGHT_WIDTH = 4,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i  [S_DATA_COUNT],
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  output logic [S_DATA_COUNT-1:0] s_ready_o,
  input  logic [WEIGHT_WIDTH-1:0] weight_i  [S_DATA_COUNT],
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    busy_o
`ifdef STREAM_WRR_STATS_EN
  ,
  output logic [15:0]             pkt_cnt_o [S_DATA_COUNT],
  input  logic                    stats_clr_i
`endif
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [T_ID___WIDTH:0]   S_EXT   = (T_ID___WIDTH+1)'(S_DATA_COUNT);
  localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(S_DATA_COUNT - 1);
  localparam logic [WEIGHT_WIDTH-1:0] ONE     = WEIGHT_WIDTH'(1);

  state_t                  state, state_n;
  logic [T_ID___WIDTH-1:0] ptr, ptr_n;
  logic [T_ID___WIDTH-1:0] grant, grant_n;
  logic [T_ID___WIDTH-1:0] pick, next_ptr;
  logic [T_ID___WIDTH:0]   cand;
  logic [WEIGHT_WIDTH-1:0] credit, credit_n, credit_load;
  logic                    pkt_open, pkt_open_n;
  logic                    first, first_n;
  logic                    any_valid;
  logic                    hs;

  // Rotating priority search; cand stays below 2*S so one conditional subtract wraps it.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
      cand = {1'b0, ptr} + (T_ID___WIDTH+1)'(i);
      if (cand >= S_EXT) cand = cand - S_EXT;
      if (!any_valid && s_valid_i[cand[T_ID___WIDTH-1:0]]) begin
        any_valid = 1'b1;
        pick      = cand[T_ID___WIDTH-1:0];
      end
    end
  end

  assign credit_load = (weight_i[pick] == '0) ? ONE : weight_i[pick];
  assign next_ptr    = (grant == LAST_ID) ? '0 : grant + 1'b1;
  assign busy_o      = (state == XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      credit   <= '0;
      pkt_open <= 1'b0;
      first    <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      grant    <= grant_n;
      credit   <= credit_n;
      pkt_open <= pkt_open_n;
      first    <= first_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_n    = grant;
    credit_n   = credit;
    pkt_open_n = pkt_open;
    first_n    = 1'b0;
    hs         = 1'b0;
    s_ready_o  = '0;
    m_data_o   = '0;
    m_id_o     = '0;
    m_last_o   = 1'b0;
    m_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_n    = pick;
          credit_n   = credit_load;
          pkt_open_n = 1'b0;
          first_n    = 1'b1;
          state_n    = XFER;
        end
      end
      XFER: begin
        m_data_o         = s_data_i[grant];
        m_last_o         = s_last_i[grant];
        m_valid_o        = s_valid_i[grant];
        m_id_o           = grant;
        s_ready_o[grant] = m_ready_i;
        hs               = s_valid_i[grant] && m_ready_i;
        if (hs) begin
          if (!s_last_i[grant]) begin
            pkt_open_n = 1'b1;
          end else begin
            pkt_open_n = 1'b0;
            credit_n   = credit - ONE;
            if (credit == ONE) begin
              state_n = IDLE;
              ptr_n   = next_ptr;
            end
          end
        end else if (!pkt_open && !first && !s_valid_i[grant]) begin
          // Idle at a packet boundary: give the port away, forfeiting leftover credit.
          state_n = IDLE;
          ptr_n   = next_ptr;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef STREAM_WRR_STATS_EN
  logic pkt_done;
  assign pkt_done = hs && s_last_i[grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_o <= '{default: '0};
    end else if (stats_clr_i) begin
      pkt_cnt_o <= '{default: '0};
    end else if (pkt_done) begin
      pkt_cnt_o[grant] <= pkt_cnt_o[grant] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Directed bench for stream_wrr_arbiter (S=4): reset, round robin, weights, early release, backpressure.
module tb_stream_wrr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] s_data  [4];
  logic [3:0] s_last;
  logic [3:0] s_valid;
  logic [3:0] s_ready;
  logic [3:0] weight  [4];
  logic [7:0] m_data;
  logic [1:0] m_id;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
`ifdef STREAM_WRR_STATS_EN
  logic [15:0] pkt_cnt [4];
  logic        stats_clr;
`endif

  int checks = 0;
  int errors = 0;
  int wseq [13] = '{-1, 0, 0, 0, -1, 1, -1, 2, -1, 3, 3, -1, 0};
  logic [1:0] id;

  stream_wrr_arbiter #(
    .T_DATA_WIDTH(8),
    .S_DATA_COUNT(4),
    .WEIGHT_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .weight_i  (weight),
    .m_data_o  (m_data),
    .m_id_o    (m_id),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .busy_o    (busy)
`ifdef STREAM_WRR_STATS_EN
    ,
    .pkt_cnt_o   (pkt_cnt),
    .stats_clr_i (stats_clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] gid);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_id"}, 32'(m_id), 32'(gid));
    chk({tag, "_ready"}, 32'(s_ready), 32'd1 << gid);
  endtask

  initial begin
    rst     = 1'b1;
    m_ready = 1'b1;
    s_valid = '1;
    s_last  = '0;
    for (int n = 0; n < 4; n++) begin
      s_data[n] = '0;
      weight[n] = 4'd1;
    end
`ifdef STREAM_WRR_STATS_EN
    stats_clr = 1'b0;
`endif
    tick;
    tick;
    chk_idle("rst");
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_id", 32'(m_id), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);

    // Reset mid-packet: input 1, 4-beat packet, reset after two beats
    rst = 1'b0;
    s_valid = 4'b0010;
    s_data[1] = 8'h10;
    #1;
    chk_idle("mid_idle");
    tick;
    chk_grant("mid_g1", 2'd1);
    chk("mid_d0", 32'(m_data), 32'h10);
    tick;
    s_data[1] = 8'h11;
    #1;
    chk("mid_d1", 32'(m_data), 32'h11);
    tick;
    s_data[1] = 8'h12;
    rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_id", 32'(m_id), 32'd0);
    tick;
    rst = 1'b0;
    s_valid = 4'b1010;
    s_data[3] = 8'h30;
    s_last[3] = 1'b1;
    #1;
    chk_idle("mid_rearb_idle");
    tick;
    chk_grant("mid_rearb", 2'd1);
    chk("mid_d2", 32'(m_data), 32'h12);
    tick;
    s_data[1] = 8'h13;
    s_last[1] = 1'b1;
    #1;
    chk("mid_d3", 32'(m_data), 32'h13);
    chk("mid_last", 32'(m_last), 32'd1);
    tick;
    s_valid = '0;
    #1;
    chk_idle("mid_done");

    // Round robin: all weights 1, 2-beat packets on every input
    rst = 1'b1;
    tick;
    rst = 1'b0;
    s_valid = '1;
    s_last = '0;
    for (int n = 0; n < 4; n++) s_data[n] = 8'(n * 16);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk_idle("rr_gap");
      tick;
      id = 2'(k % 4);
      for (int b = 0; b < 2; b++) begin
        chk_grant("rr", id);
        chk("rr_data", 32'(m_data), 32'(id) * 16 + 32'(b));
        chk("rr_last", 32'(m_last), 32'(b));
        tick;
        if (b == 0) begin
          s_data[id] = 8'(32'(id) * 16 + 1);
          s_last[id] = 1'b1;
        end else begin
          s_data[id] = 8'(32'(id) * 16);
          s_last[id] = 1'b0;
        end
        #1;
      end
    end

    // Weighted: {3,1,0,2}, single-beat packets, all valid
    rst = 1'b1;
    tick;
    rst = 1'b0;
    weight = '{4'd3, 4'd1, 4'd0, 4'd2};
    s_valid = '1;
    s_last = '1;
    for (int n = 0; n < 4; n++) s_data[n] = 8'(8'hA0 + n);
    #1;
    for (int c = 0; c < 13; c++) begin
      if (wseq[c] < 0) begin
        chk_idle("wrr_gap");
      end else begin
        chk_grant("wrr", 2'(wseq[c]));
        chk("wrr_data", 32'(m_data), 32'hA0 + 32'(wseq[c]));
      end
      tick;
    end

    // Early release: input 0 weight 4 sends one packet then drops valid
    rst = 1'b1;
    tick;
    rst = 1'b0;
    weight = '{4'd4, 4'd1, 4'd1, 4'd1};
    s_valid = 4'b0101;
    s_last = '1;
    s_data[0] = 8'h50;
    s_data[2] = 8'h70;
    #1;
    chk_idle("er_idle");
    tick;
    chk_grant("er_g0", 2'd0);
    chk("er_d0", 32'(m_data), 32'h50);
    tick;
    s_valid[0] = 1'b0;
    #1;
    chk("er_hold_busy", 32'(busy), 32'd1);
    chk("er_hold_valid", 32'(m_valid), 32'd0);
    tick;
    chk_idle("er_release");
    tick;
    s_valid[0] = 1'b1;
    #1;
    chk_grant("er_g2", 2'd2);
    chk("er_d2", 32'(m_data), 32'h70);
    tick;
    chk_idle("er_gap");
    tick;
    chk_grant("er_wrap", 2'd0);

    // Backpressure: 3-beat packet on input 1, stall on beat 2
    rst = 1'b1;
    tick;
    rst = 1'b0;
    weight = '{4'd1, 4'd1, 4'd1, 4'd1};
    s_valid = 4'b1110;
    s_last = '0;
    s_data[1] = 8'h81;
    #1;
    chk_idle("bp_idle");
    tick;
    chk_grant("bp_g1", 2'd1);
    chk("bp_d1", 32'(m_data), 32'h81);
    tick;
    s_data[1] = 8'h82;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall_data", 32'(m_data), 32'h82);
      chk("bp_stall_id", 32'(m_id), 32'd1);
      chk("bp_stall_ready", 32'(s_ready), 32'd0);
      tick;
    end
    m_ready = 1'b1;
    s_valid[1] = 1'b0;
    #1;
    chk("bp_gap_busy", 32'(busy), 32'd1);
    chk("bp_gap_id", 32'(m_id), 32'd1);
    chk("bp_gap_valid", 32'(m_valid), 32'd0);
    tick;
    s_valid[1] = 1'b1;
    #1;
    chk_grant("bp_resume", 2'd1);
    chk("bp_d2", 32'(m_data), 32'h82);
    tick;
    s_data[1] = 8'h83;
    s_last[1] = 1'b1;
    #1;
    chk("bp_d3", 32'(m_data), 32'h83);
    chk("bp_last", 32'(m_last), 32'd1);
    tick;
    chk_idle("bp_done");
    tick;
    chk_grant("bp_next", 2'd2);

`ifdef STREAM_WRR_STATS_EN
    // Counters: 10 packets from input 3, then clear colliding with an 11th
    rst = 1'b1;
    tick;
    rst = 1'b0;
    s_valid = 4'b1000;
    s_last = 4'b1000;
    s_data[3] = 8'h3C;
    repeat (20) tick;
    chk("st_cnt10", 32'(pkt_cnt[3]), 32'd10);
    chk("st_cnt0", 32'(pkt_cnt[0]), 32'd0);
    chk_idle("st_idle");
    tick;
    stats_clr = 1'b1;
    #1;
    chk_grant("st_g3", 2'd3);
    tick;
    stats_clr = 1'b0;
    #1;
    chk("st_clr", 32'(pkt_cnt[3]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
